memory_access: RTL and testbench

//  MEM stage of the 5-stage RV32I pipeline; sits directly downstream of execute.

---
 rtl/memory_access_pkg.sv | 37 +++
 rtl/memory_access_mem_align.sv | 58 +++++
 rtl/memory_access.sv | 252 +++++++++++++++++++++++++
 tb/tb_memory_access.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared types for the MEM stage: pipeline handshake structs, decode info and FSM states.
// funct3 encodings for the RV32I load/store width field live here too.
package memory_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic       stall_req;
        logic [3:0] flush_req;
    } PipeRequest;

    typedef struct packed {
        logic stall;
        logic flush;
    } PipeControl;

    typedef struct packed {
        logic       enable;
        logic       rd_valid;
        logic [4:0] rd;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } DecodeInfo;

endpackage

// File: rtl/memory_access_mem_align.sv
// Byte-lane steering for the data bus: store strobes/replication, load extraction and
// alignment check. Purely combinational.
module mem_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'd0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'd0, lane_h};
            F3_W:    load_data = rdata;
            default: load_data = rdata;
        endcase
    end

    // Width is funct3[1:0]; bit 2 only selects zero-extension on loads.
    always_comb begin
        misaligned = 1'b0;
        wstrb      = 4'hF;
        wdata      = store_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage of the RV32I pipeline: issues loads/stores on a req/gnt/rvalid bus, stalls while
// an access is outstanding, and registers the result for writeback and forwarding.
//
//   state | meaning
//   IDLE  | accept instr from EX; issue bus request for aligned memops
//   REQ   | request pending, waiting for gnt; bus outputs held from latches
//   RESP  | granted, waiting for rvalid; watchdog running
//   DONE  | result buffered, waiting for pipeline to advance
module memory_access
    import memory_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    output PipeRequest  req,
    input  PipeControl  pipe,
    input  DecodeInfo   info,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_out,
    output DecodeInfo   info_ff,
    output logic        fault
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    mem_state_t state_q, state_d;

    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            we_q, we_d;
    DecodeInfo       linfo_q, linfo_d;
    logic [31:0]     buf_q, buf_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            kill_q, kill_d;
    logic            to_q, to_d;
    logic [31:0]     mem_out_q, mem_out_d;
    DecodeInfo       info_q, info_d;
    logic            fault_q, fault_d;

    logic [2:0]  a_f3;
    logic [1:0]  a_lo;
    logic [3:0]  a_wstrb;
    logic [31:0] a_wdata;
    logic [31:0] a_load;
    logic        a_mis;
    logic        memop;
    logic        issue;
    logic        wd_expire;
    logic        stall_req;

    // Store formatting is needed at issue (live inputs); load extraction at rvalid (latched).
    assign a_f3 = (state_q == IDLE) ? info.funct3 : linfo_q.funct3;
    assign a_lo = (state_q == IDLE) ? alu_out[1:0] : addr_q[1:0];

    mem_align u_align (
        .funct3     (a_f3),
        .addr_lo    (a_lo),
        .store_data (store_data),
        .rdata      (dmem_rdata),
        .wstrb      (a_wstrb),
        .wdata      (a_wdata),
        .load_data  (a_load),
        .misaligned (a_mis)
    );

    assign memop     = info.enable && (info.mem_read || info.mem_write);
    assign issue     = (state_q == IDLE) && memop && !a_mis && !pipe.flush;
    assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue) state_d = dmem_gnt ? RESP : REQ;
            end
            REQ: begin
                if (dmem_gnt)        state_d = RESP;
                else if (pipe.flush) state_d = IDLE;
            end
            RESP: begin
                if (dmem_rvalid || wd_expire) state_d = DONE;
            end
            DONE: begin
                if (!pipe.stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = we_q;
        dmem_addr  = {addr_q[31:2], 2'b00};
        dmem_wdata = wdata_q;
        dmem_wstrb = wstrb_q;
        stall_req  = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_req   = issue;
                dmem_we    = info.mem_write;
                dmem_addr  = {alu_out[31:2], 2'b00};
                dmem_wdata = a_wdata;
                dmem_wstrb = info.mem_write ? a_wstrb : 4'h0;
                stall_req  = issue;
            end
            REQ: begin
                dmem_req  = 1'b1;
                stall_req = 1'b1;
            end
            RESP:    stall_req = 1'b1;
            default: stall_req = 1'b0;
        endcase
    end

    assign req = {stall_req, 4'b0000};

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        linfo_d = linfo_q;
        buf_d   = buf_q;
        wd_d    = wd_q;
        kill_d  = kill_q;
        to_d    = to_q;
        if (issue) begin
            addr_d  = alu_out;
            wdata_d = a_wdata;
            wstrb_d = info.mem_write ? a_wstrb : 4'h0;
            we_d    = info.mem_write;
            linfo_d = info;
            buf_d   = '0;
            wd_d    = WD_W'(TIMEOUT);
            kill_d  = 1'b0;
            to_d    = 1'b0;
        end
        case (state_q)
            REQ: begin
                if (dmem_gnt && pipe.flush) kill_d = 1'b1;
            end
            RESP: begin
                // A killed access still waits for its response so a granted store commits.
                if (pipe.flush) kill_d = 1'b1;
                if (dmem_rvalid)           buf_d = we_q ? 32'd0 : a_load;
                else if (wd_expire)        to_d  = 1'b1;
                else if (TIMEOUT != 0)     wd_d  = wd_q - WD_W'(1);
            end
            DONE: begin
                if (pipe.flush) kill_d = 1'b1;
                if (!pipe.stall) begin
                    kill_d = 1'b0;
                    to_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_out_d = mem_out_q;
        info_d    = info_q;
        fault_d   = fault_q;
        if (!pipe.stall) begin
            if (pipe.flush) begin
                mem_out_d = '0;
                info_d    = '0;
                fault_d   = 1'b0;
            end else if (state_q == IDLE && !issue) begin
                if (memop) begin
                    mem_out_d       = '0;
                    info_d          = info;
                    info_d.rd_valid = 1'b0;
                    fault_d         = 1'b1;
                end else begin
                    mem_out_d = alu_out;
                    info_d    = info;
                    fault_d   = 1'b0;
                end
            end else if (state_q == DONE) begin
                if (kill_q) begin
                    mem_out_d = '0;
                    info_d    = '0;
                    fault_d   = 1'b0;
                end else if (to_q) begin
                    mem_out_d       = '0;
                    info_d          = linfo_q;
                    info_d.rd_valid = 1'b0;
                    fault_d         = 1'b1;
                end else begin
                    mem_out_d = buf_q;
                    info_d    = linfo_q;
                    fault_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            we_q      <= 1'b0;
            linfo_q   <= '0;
            buf_q     <= '0;
            wd_q      <= '0;
            kill_q    <= 1'b0;
            to_q      <= 1'b0;
            mem_out_q <= '0;
            info_q    <= '0;
            fault_q   <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            we_q      <= we_d;
            linfo_q   <= linfo_d;
            buf_q     <= buf_d;
            wd_q      <= wd_d;
            kill_q    <= kill_d;
            to_q      <= to_d;
            mem_out_q <= mem_out_d;
            info_q    <= info_d;
            fault_q   <= fault_d;
        end
    end

    assign mem_out = mem_out_q;
    assign info_ff = info_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: acts as hazard unit and data-bus slave, and checks
// results against a scoreboard of expected writeback values.
module tb_memory_access;
    import memory_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    PipeRequest  preq;
    PipeControl  pipe;
    DecodeInfo   info;
    logic [31:0] alu_out, store_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] mem_out;
    DecodeInfo   info_ff;
    logic        fault;

    always #5 clk = ~clk;

    memory_access #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (preq),
        .pipe        (pipe),
        .info        (info),
        .alu_out     (alu_out),
        .store_data  (store_data),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .mem_out     (mem_out),
        .info_ff     (info_ff),
        .fault       (fault)
    );

    typedef struct packed {
        logic [31:0] mem_out;
        DecodeInfo   info;
        logic        fault;
    } res_t;

    res_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_strb;
    logic        exp_we;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic DecodeInfo mk(input logic rdv, input logic [4:0] rd, input logic mr,
                                     input logic mw, input logic [2:0] f3);
        DecodeInfo d;
        d.enable    = 1'b1;
        d.rd_valid  = rdv;
        d.rd        = rd;
        d.mem_read  = mr;
        d.mem_write = mw;
        d.funct3    = f3;
        return d;
    endfunction

    function automatic DecodeInfo no_rd(input DecodeInfo d);
        DecodeInfo r;
        r = d;
        r.rd_valid = 1'b0;
        return r;
    endfunction

    task automatic push(input logic [31:0] m, input DecodeInfo i, input logic f);
        res_t r;
        r.mem_out = m;
        r.info    = i;
        r.fault   = f;
        sb.push_back(r);
    endtask

    task automatic set_bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] w,
                           input logic we);
        exp_addr  = a;
        exp_strb  = s;
        exp_wdata = w;
        exp_we    = we;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the stage advanced.
    task automatic run_op(input string tag, input DecodeInfo inf, input logic [31:0] a,
                          input logic [31:0] sd, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rd, input bit no_rv, input int flush_at,
                          input int exp_stalls, input int exp_reqs);
        int   cyc = 0;
        int   gwait = 0;
        int   rwait = 0;
        int   stalls = 0;
        int   reqs = 0;
        bit   granted = 1'b0;
        bit   rv_seen = 1'b0;
        bit   done = 1'b0;
        res_t e;
        info       = inf;
        alu_out    = a;
        store_data = sd;
        while (!done && cyc < 40) begin
            if (flush_at >= 0 && cyc > flush_at) begin
                info    = '0;
                alu_out = '0;
            end
            pipe.flush  = (cyc == flush_at);
            pipe.stall  = 1'b0;
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = '0;
            #1;
            pipe.stall = preq.stall_req;
            if (preq.stall_req) stalls++;
            if (dmem_req) begin
                reqs++;
                check({tag, ".addr"}, 64'(dmem_addr), 64'(exp_addr));
                check({tag, ".strb"}, 64'(dmem_wstrb), 64'(exp_strb));
                check({tag, ".we"}, 64'(dmem_we), 64'(exp_we));
                if (exp_we) check({tag, ".wdata"}, 64'(dmem_wdata), 64'(exp_wdata));
                if (!granted) begin
                    if (gwait == gnt_dly) begin
                        dmem_gnt = 1'b1;
                        granted  = 1'b1;
                    end else begin
                        gwait++;
                    end
                end
            end else if (granted && !rv_seen && !no_rv) begin
                if (rwait == rv_dly) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rd;
                    rv_seen     = 1'b1;
                end else begin
                    rwait++;
                end
            end
            if (!preq.stall_req) done = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        pipe        = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        check({tag, ".completed"}, 64'(done), 64'(1));
        check({tag, ".stalls"}, 64'(stalls), 64'(exp_stalls));
        check({tag, ".reqs"}, 64'(reqs), 64'(exp_reqs));
        e = sb.pop_front();
        check({tag, ".mem_out"}, 64'(mem_out), 64'(e.mem_out));
        check({tag, ".info_ff"}, 64'(info_ff), 64'(e.info));
        check({tag, ".fault"}, 64'(fault), 64'(e.fault));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed run still active, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        DecodeInfo i_lw, i_lb, i_lbu, i_lh, i_lhu, i_sh, i_sb, i_sw, i_add;
        i_lw  = mk(1'b1, 5'd5, 1'b1, 1'b0, F3_W);
        i_lb  = mk(1'b1, 5'd6, 1'b1, 1'b0, F3_B);
        i_lbu = mk(1'b1, 5'd7, 1'b1, 1'b0, F3_BU);
        i_lh  = mk(1'b1, 5'd8, 1'b1, 1'b0, F3_H);
        i_lhu = mk(1'b1, 5'd9, 1'b1, 1'b0, F3_HU);
        i_sh  = mk(1'b0, 5'd0, 1'b0, 1'b1, F3_H);
        i_sb  = mk(1'b0, 5'd0, 1'b0, 1'b1, F3_B);
        i_sw  = mk(1'b0, 5'd0, 1'b0, 1'b1, F3_W);
        i_add = mk(1'b1, 5'd10, 1'b0, 1'b0, 3'b000);

        rst         = 1'b1;
        pipe        = '0;
        info        = '0;
        alu_out     = '0;
        store_data  = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.mem_out", 64'(mem_out), 64'(0));
        check("reset.info_ff", 64'(info_ff), 64'(0));
        check("reset.fault", 64'(fault), 64'(0));
        check("reset.stall_req", 64'(preq.stall_req), 64'(0));
        check("reset.flush_req", 64'(preq.flush_req), 64'(0));
        rst = 1'b0;

        set_bus(32'h100, 4'h0, 32'h0, 1'b0);
        push(32'hDEADBEEF, i_lw, 1'b0);
        run_op("lw", i_lw, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, -1, 2, 1);

        push(32'hFFFFFF80, i_lb, 1'b0);
        run_op("lb", i_lb, 32'h103, 32'h0, 0, 0, 32'h80FF_0000, 1'b0, -1, 2, 1);
        push(32'h00000080, i_lbu, 1'b0);
        run_op("lbu", i_lbu, 32'h103, 32'h0, 0, 0, 32'h80FF_0000, 1'b0, -1, 2, 1);
        push(32'hFFFF80FF, i_lh, 1'b0);
        run_op("lh", i_lh, 32'h102, 32'h0, 0, 0, 32'h80FF_0000, 1'b0, -1, 2, 1);
        push(32'h000080FF, i_lhu, 1'b0);
        run_op("lhu", i_lhu, 32'h102, 32'h0, 0, 0, 32'h80FF_0000, 1'b0, -1, 2, 1);

        set_bus(32'h204, 4'b1100, 32'hABCDABCD, 1'b1);
        push(32'h0, i_sh, 1'b0);
        run_op("sh", i_sh, 32'h206, 32'h1234ABCD, 3, 0, 32'h0, 1'b0, -1, 5, 4);

        set_bus(32'h300, 4'b0010, 32'hA5A5A5A5, 1'b1);
        push(32'h0, i_sb, 1'b0);
        run_op("sb", i_sb, 32'h301, 32'h000000A5, 0, 0, 32'h0, 1'b0, -1, 2, 1);

        push(32'h12345678, i_add, 1'b0);
        run_op("add", i_add, 32'h12345678, 32'h0, 0, 0, 32'h0, 1'b0, -1, 0, 0);

        set_bus(32'h400, 4'hF, 32'hCAFEF00D, 1'b1);
        push(32'h0, i_sw, 1'b0);
        run_op("sw", i_sw, 32'h400, 32'hCAFEF00D, 0, 2, 32'h0, 1'b0, -1, 4, 1);

        push(32'h0, no_rd(i_lw), 1'b1);
        run_op("lw_mis", i_lw, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0, -1, 0, 0);
        push(32'h0, i_sh, 1'b1);
        run_op("sh_mis", i_sh, 32'h203, 32'h0, 0, 0, 32'h0, 1'b0, -1, 0, 0);

        set_bus(32'h180, 4'h0, 32'h0, 1'b0);
        push(32'h55AA55AA, i_lw, 1'b0);
        run_op("lw2", i_lw, 32'h180, 32'h0, 0, 1, 32'h55AA55AA, 1'b0, -1, 3, 1);

        set_bus(32'h500, 4'h0, 32'h0, 1'b0);
        push(32'h0, '0, 1'b0);
        run_op("flush_req", i_lw, 32'h500, 32'h0, 5, 0, 32'h0, 1'b0, 1, 2, 2);

        set_bus(32'h180, 4'h0, 32'h0, 1'b0);
        push(32'h0BADCAFE, i_lw, 1'b0);
        run_op("lw3", i_lw, 32'h180, 32'h0, 0, 0, 32'h0BADCAFE, 1'b0, -1, 2, 1);

        set_bus(32'h600, 4'h0, 32'h0, 1'b0);
        push(32'h0, '0, 1'b0);
        run_op("flush_resp", i_lw, 32'h600, 32'h0, 0, 1, 32'h11111111, 1'b0, 1, 3, 1);

        set_bus(32'h700, 4'h0, 32'h0, 1'b0);
        push(32'h0, no_rd(i_lw), 1'b1);
        run_op("timeout", i_lw, 32'h700, 32'h0, 0, 0, 32'h0, 1'b1, -1, 5, 1);

        // Reset arriving while a load waits for its response.
        info    = i_lw;
        alu_out = 32'h800;
        #1;
        dmem_gnt = dmem_req;
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        check("rst_mid.pre_stall", 64'(preq.stall_req), 64'(1));
        rst     = 1'b1;
        info    = '0;
        alu_out = '0;
        #1;
        check("rst_mid.mem_out", 64'(mem_out), 64'(0));
        check("rst_mid.info_ff", 64'(info_ff), 64'(0));
        check("rst_mid.fault", 64'(fault), 64'(0));
        check("rst_mid.dmem_req", 64'(dmem_req), 64'(0));
        check("rst_mid.stall_req", 64'(preq.stall_req), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid.idle_after", 64'(preq.stall_req), 64'(0));

        set_bus(32'h900, 4'h0, 32'h0, 1'b0);
        push(32'h0BADF00D, i_lw, 1'b0);
        run_op("lw_after_rst", i_lw, 32'h900, 32'h0, 0, 0, 32'h0BADF00D, 1'b0, -1, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
